spi_slave_mode: RTL and testbench

Parametrised SPI slave with all four SPI modes (CPOL/CPHA), configurable word width and MSB/LSB-first bit order. It runs entirely in the fclk domain and oversamples sck, cs_n and mosi.
- TX side: valid/ready holding register, with underrun detection.
- RX side: valid/ack, with overrun detection.
It sits between the external SPI pins and the register/command layer. Back-to-back multi-word frames are supported within one cs_n assertion.

---
 rtl/spi_slave_mode.sv | 189 ++++++++++++++++++
 tb/tb_spi_slave_mode.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_mode.sv
// SPI slave, all four CPOL/CPHA modes, WIDTH-bit words, MSB/LSB-first, pins oversampled in fclk.
// Pin edges act SYNC_STAGES+1 fclk later; TX holding register is valid/ready, RX is valid/ack with sticky overrun/underrun.
module spi_slave_mode #(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] UNDERRUN_FILL = {WIDTH{1'b1}},
  parameter int               SYNC_STAGES   = 2
) (
  input  logic             fclk,
  input  logic             rst_n,
  input  logic             sck,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             lsb_first,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ack,
  output logic             busy,
  output logic             frame_end,
  output logic             overrun,
  output logic             underrun,
  input  logic             flag_clr
);

  localparam int            CW        = $clog2(WIDTH);
  localparam logic [CW-1:0] BCNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SEL = 1'b1} state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
    logic lsb;
  } mode_t;

  state_t state, state_nxt;
  mode_t  mode_q, mode_cur;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_d, cs_d;
  logic                   sck_s, cs_s, mosi_s;

  logic             cs_fall, cs_rise, start, stop;
  logic             sck_edge, lead, trail, sample, shift, last, load;
  logic [CW-1:0]    bcnt;
  logic [WIDTH-1:0] tx_sh, rx_sh, hold;
  logic             hold_full, miso_q;
  logic [WIDTH-1:0] load_word, pop_src, pop_rest, rx_word;
  logic             pop_bit, do_pop, tx_wr;

  // Synchronisers; registers clear to 0 so a cs_n already low at reset release never looks like a fall.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign cs_fall  = cs_d & ~cs_s;
  assign cs_rise  = ~cs_d & cs_s;
  assign start    = (state == IDLE) && cs_fall;
  assign stop     = (state == SEL) && cs_rise;
  assign sck_edge = (state == SEL) && !cs_rise && (sck_s ^ sck_d);
  assign lead     = sck_edge && (sck_d == mode_q.cpol);
  assign trail    = sck_edge && (sck_s == mode_q.cpol);
  assign sample   = mode_q.cpha ? trail : lead;
  assign shift    = mode_q.cpha ? lead : trail;
  assign last     = sample && (bcnt == BCNT_LAST);
  assign load     = start || last;
  assign tx_wr    = tx_valid && !hold_full;

  // The load at cs_n fall must already honour the pin mode that is being latched.
  always_comb begin
    mode_cur = mode_q;
    if (start) mode_cur = mode_t'({cpol, cpha, lsb_first});
  end

  always_comb begin
    load_word = hold_full ? hold : UNDERRUN_FILL;
    pop_src   = load ? load_word : tx_sh;
    pop_bit   = mode_cur.lsb ? pop_src[0] : pop_src[WIDTH-1];
    pop_rest  = mode_cur.lsb ? (pop_src >> 1) : (pop_src << 1);
    rx_word   = mode_q.lsb ? {mosi_s, rx_sh[WIDTH-1:1]} : {rx_sh[WIDTH-2:0], mosi_s};
    // CPHA=0 shows bit 0 at load, so the trailing edge right after a word boundary must not advance it.
    if (load) do_pop = !mode_cur.cpha;
    else      do_pop = shift && (mode_q.cpha || (bcnt != '0));
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = SEL;
      SEL:     if (cs_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == SEL);
    miso_oe = (state == SEL);
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= '0;
      bcnt   <= '0;
      rx_sh  <= '0;
      tx_sh  <= '0;
      miso_q <= 1'b0;
    end else if (stop) begin
      bcnt   <= '0;
      rx_sh  <= '0;
      tx_sh  <= '0;
      miso_q <= 1'b0;
    end else begin
      if (start) mode_q <= mode_cur;
      if (sample) begin
        rx_sh <= rx_word;
        bcnt  <= last ? '0 : bcnt + CW'(1);
      end
      if (do_pop) begin
        miso_q <= pop_bit;
        tx_sh  <= pop_rest;
      end else if (load) begin
        tx_sh  <= load_word;
      end
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      hold_full <= 1'b0;
    end else if (tx_wr) begin
      hold      <= tx_data;
      hold_full <= 1'b1;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      if (last) begin
        rx_data  <= rx_word;
        rx_valid <= 1'b1;
      end else if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
      end
      overrun   <= (last && rx_valid && !rx_ack) || (overrun && !flag_clr);
      underrun  <= (load && !hold_full) || (underrun && !flag_clr);
      frame_end <= stop;
    end
  end

  assign miso     = miso_q;
  assign tx_ready = !hold_full;

endmodule

// File: tb/tb_spi_slave_mode.sv
// Bench for spi_slave_mode: SPI master driver with a transaction-level model of the holding register and flags,
// expected words queued at issue time and compared by separate monitor processes.
module tb_spi_slave_mode;
  localparam int HALF = 10;

  logic       fclk, rst_n, sck, cs_n, mosi, miso, miso_oe;
  logic       cpol, cpha, lsb_first;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ack;
  logic       busy, frame_end, overrun, underrun, flag_clr;

  spi_slave_mode #(.WIDTH(8), .UNDERRUN_FILL(8'hFF), .SYNC_STAGES(2)) dut (
    .fclk(fclk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .busy(busy), .frame_end(frame_end), .overrun(overrun), .underrun(underrun),
    .flag_clr(flag_clr)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] rx_exp[$];
  logic [7:0] miso_exp[$];
  logic [7:0] miso_obs[$];

  logic [7:0] m_hold, m_last_rx;
  bit m_full, m_under, m_over, m_unread;
  bit auto_ack = 1'b1;
  bit d_cpol, d_cpha, d_lsb;
  int frames_exp = 0;
  int fe_count = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one holding slot; every word boundary drains it or substitutes the fill word.
  task automatic model_load(input bit push);
    logic [7:0] e;
    e = m_full ? m_hold : 8'hFF;
    if (!m_full) m_under = 1'b1;
    m_full = 1'b0;
    if (push) miso_exp.push_back(e);
  endtask

  task automatic tx_write(input logic [7:0] d);
    int t;
    t = 0;
    while (!tx_ready && t < 200) begin
      @(negedge fclk);
      t++;
    end
    if (!tx_ready) begin
      chk("tx_ready_timeout", 32'(tx_ready), 1);
      return;
    end
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge fclk);
    tx_valid = 1'b0;
    m_hold   = d;
    m_full   = 1'b1;
  endtask

  task automatic flag_clear();
    @(negedge fclk);
    flag_clr = 1'b1;
    @(negedge fclk);
    flag_clr = 1'b0;
    m_under  = 1'b0;
    m_over   = 1'b0;
    @(negedge fclk);
    chk("underrun_clr", 32'(underrun), 0);
    chk("overrun_clr", 32'(overrun), 0);
  endtask

  task automatic cs_fall_t(input bit pl, input bit ph, input bit lsb);
    d_cpol = pl; d_cpha = ph; d_lsb = lsb;
    cpol = pl; cpha = ph; lsb_first = lsb;
    sck = pl;
    mosi = 1'b0;
    repeat (HALF) @(negedge fclk);
    cs_n = 1'b0;
    model_load(1'b1);
    repeat (HALF) @(negedge fclk);
    chk("busy_sel", 32'(busy), 1);
    chk("miso_oe_sel", 32'(miso_oe), 1);
    chk("tx_ready_after_fall", 32'(tx_ready), 32'(!m_full));
    chk("underrun_in_frame", 32'(underrun), 32'(m_under));
    // Mode pins wander mid-frame; the slave must keep the latched mode.
    cpol = 1'($urandom); cpha = 1'($urandom); lsb_first = 1'($urandom);
  endtask

  task automatic send_word(input logic [7:0] w, input int nbits, input bit more,
                           input bit wr_mid, input logic [7:0] wd);
    logic [7:0] cap;
    int idx;
    cap = '0;
    if (nbits == 8) begin
      if (auto_ack) rx_exp.push_back(w);
      else begin
        if (m_unread) m_over = 1'b1;
        m_unread  = 1'b1;
        m_last_rx = w;
      end
    end
    for (int i = 0; i < nbits; i++) begin
      idx = d_lsb ? i : 7 - i;
      if (i == 3 && wr_mid && !m_full) tx_write(wd);
      if (!d_cpha) begin
        mosi = w[idx];
        repeat (HALF) @(negedge fclk);
        cap[idx] = miso;
        sck = ~d_cpol;
        repeat (HALF) @(negedge fclk);
        sck = d_cpol;
      end else begin
        sck  = ~d_cpol;
        mosi = w[idx];
        repeat (HALF) @(negedge fclk);
        cap[idx] = miso;
        sck = d_cpol;
        repeat (HALF) @(negedge fclk);
      end
    end
    if (nbits == 8) begin
      miso_obs.push_back(cap);
      model_load(more);
    end else if (miso_exp.size() > 0) begin
      void'(miso_exp.pop_front());
    end
  endtask

  task automatic cs_rise_t(input bit counted);
    repeat (HALF) @(negedge fclk);
    cs_n = 1'b1;
    if (counted) frames_exp++;
    repeat (HALF) @(negedge fclk);
    chk("frame_end_count", 32'(fe_count), 32'(frames_exp));
    chk("busy_idle", 32'(busy), 0);
    chk("miso_oe_idle", 32'(miso_oe), 0);
    chk("miso_idle", 32'(miso), 0);
    chk("underrun_post", 32'(underrun), 32'(m_under));
    chk("overrun_post", 32'(overrun), 32'(m_over));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_miso"}, 32'(miso), 0);
    chk({tag, "_miso_oe"}, 32'(miso_oe), 0);
    chk({tag, "_tx_ready"}, 32'(tx_ready), 1);
    chk({tag, "_rx_valid"}, 32'(rx_valid), 0);
    chk({tag, "_rx_data"}, 32'(rx_data), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_frame_end"}, 32'(frame_end), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
    chk({tag, "_underrun"}, 32'(underrun), 0);
  endtask

  // RX monitor: every presented word is compared against the queue and acknowledged.
  initial begin
    rx_ack = 1'b0;
    forever begin
      @(negedge fclk);
      if (rx_ack) rx_ack = 1'b0;
      else if (rx_valid && auto_ack) begin
        if (rx_exp.size() == 0) chk("rx_unexpected", 32'(rx_valid), 0);
        else chk("rx_data", 32'(rx_data), 32'(rx_exp.pop_front()));
        rx_ack = 1'b1;
      end
    end
  end

  initial begin
    logic [7:0] o;
    forever begin
      @(negedge fclk);
      while (miso_obs.size() > 0) begin
        o = miso_obs.pop_front();
        if (miso_exp.size() == 0) chk("miso_unexpected", 32'(o), 32'hFFFF_FFFF);
        else chk("miso_word", 32'(o), 32'(miso_exp.pop_front()));
      end
    end
  end

  initial forever begin
    @(negedge fclk);
    if (frame_end) fe_count++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w1, w2;
    int nw, nb;
    bit pl, ph, lsb, wr;
    rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    tx_valid = 1'b0; tx_data = '0; flag_clr = 1'b0;
    m_hold = '0; m_last_rx = '0; m_full = 0; m_under = 0; m_over = 0; m_unread = 0;
    repeat (3) @(negedge fclk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge fclk);

    // Mode 0, MSB-first single word
    tx_write(8'h3C);
    cs_fall_t(0, 0, 0);
    send_word(8'hA5, 8, 0, 0, 8'h00);
    cs_rise_t(1);
    flag_clear();

    // Mode 3, two words, second TX word written during the first
    tx_write(8'h81);
    cs_fall_t(1, 1, 0);
    send_word(8'h12, 8, 1, 1, 8'h7E);
    send_word(8'h34, 8, 0, 0, 8'h00);
    cs_rise_t(1);
    flag_clear();

    // Mode 1, LSB-first
    tx_write(8'h01);
    cs_fall_t(0, 1, 1);
    send_word(8'h01, 8, 0, 0, 8'h00);
    cs_rise_t(1);
    flag_clear();

    // No TX data, no ack: underrun fill and overrun
    auto_ack = 1'b0;
    w1 = 8'($urandom); w2 = 8'($urandom);
    cs_fall_t(0, 0, 0);
    send_word(w1, 8, 1, 0, 8'h00);
    send_word(w2, 8, 0, 0, 8'h00);
    cs_rise_t(1);
    chk("rx_valid_held", 32'(rx_valid), 1);
    chk("rx_data_overwritten", 32'(rx_data), 32'(m_last_rx));
    flag_clear();
    rx_exp.push_back(m_last_rx);
    m_unread = 1'b0;
    auto_ack = 1'b1;
    repeat (6) @(negedge fclk);
    chk("rx_valid_acked", 32'(rx_valid), 0);

    // Aborted frame then a clean one
    cs_fall_t(0, 0, 0);
    send_word(8'($urandom), 5, 0, 0, 8'h00);
    cs_rise_t(1);
    chk("rx_valid_partial", 32'(rx_valid), 0);
    cs_fall_t(0, 0, 0);
    send_word(8'h5A, 8, 0, 0, 8'h00);
    cs_rise_t(1);
    flag_clear();

    // Reset mid-word with cs_n held low
    cs_fall_t(0, 0, 0);
    send_word(8'hC3, 3, 0, 0, 8'h00);
    rst_n = 1'b0;
    m_full = 0; m_under = 0; m_over = 0; m_unread = 0;
    miso_exp.delete();
    @(negedge fclk);
    chk_reset_vals("midrst");
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sck = 1'b1;
      repeat (HALF) @(negedge fclk);
      sck = 1'b0;
      repeat (HALF) @(negedge fclk);
    end
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_miso_oe", 32'(miso_oe), 0);
    chk("post_rst_rx_valid", 32'(rx_valid), 0);
    cs_rise_t(0);
    cs_fall_t(0, 0, 0);
    send_word(8'hC3, 8, 0, 0, 8'h00);
    cs_rise_t(1);
    flag_clear();

    // Randomised frames
    for (int f = 0; f < 16; f++) begin
      pl = 1'($urandom); ph = 1'($urandom); lsb = 1'($urandom);
      nw = $urandom_range(1, 3);
      if (!m_full && $urandom_range(0, 1) == 1) tx_write(8'($urandom));
      cs_fall_t(pl, ph, lsb);
      for (int k = 0; k < nw; k++) begin
        nb = 8;
        if (k == nw - 1 && $urandom_range(0, 3) == 0) nb = $urandom_range(1, 7);
        wr = 1'($urandom);
        send_word(8'($urandom), nb, k < nw - 1, wr, 8'($urandom));
      end
      cs_rise_t(1);
      if ($urandom_range(0, 1) == 1) flag_clear();
    end

    repeat (50) @(negedge fclk);
    chk("rx_exp_drained", 32'(rx_exp.size()), 0);
    chk("miso_exp_drained", 32'(miso_exp.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
